// File: rtl/simple_dma_reader_pkg.sv
// Shared widths, command record and FSM state encoding for the SDRAM read DMA.
// The command FIFO, the top level and the testbench all import this package.
package simple_dma_reader_pkg;

    localparam int ADR_W  = 28;
    localparam int DATA_W = 128;
    localparam int DONE_W = 16;
    localparam int CMD_W  = 2 * ADR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RD    = 2'd2,
        ST_DRAIN = 2'd3
    } dma_state_t;

    // One queued buffer: start word address in the upper half, length in words below.
    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [ADR_W-1:0] size;
    } dma_cmd_t;

endpackage

// File: rtl/dma_cmd_fifo.sv
// Small synchronous command FIFO with empty / almost-empty / full flags.
// DEPTH must be a power of two and at least 2; pushes while full are ignored.
module dma_cmd_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             aempty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign aempty  = (count <= ONE_CNT);
    assign full    = (count == FULL_CNT);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ONE_CNT;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ONE_CNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/simple_dma_reader.sv
// Avalon-MM read master: plays queued SDRAM buffers out to a downstream stream,
// one buffer at a time, with a bounded number of outstanding reads.
module simple_dma_reader
    import simple_dma_reader_pkg::*;
#(
    parameter int CMD_DEPTH   = 8,
    parameter int MAX_PENDING = 16
) (
    input  logic              CLK,
    input  logic              ARST_N,
    input  logic [ADR_W-1:0]  START_ADR,
    input  logic [ADR_W-1:0]  BUF_SIZE,
    input  logic              START,
    output logic [DONE_W-1:0] DONE_CNT,
    output logic              CMD_FIFO_EMPTY,
    output logic              CMD_FIFO_AEMPTY,
    output logic              CMD_OVF,
    output logic              BUSY,
    input  logic              DST_AFULL,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_DV,
    output logic [ADR_W-1:0]  SDRAM_ADDRESS,
    output logic              SDRAM_READ,
    input  logic              SDRAM_WAITREQUEST,
    input  logic [DATA_W-1:0] SDRAM_READDATA,
    input  logic              SDRAM_READDATAVALID,
    output dma_state_t        DBG_STATE
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [ADR_W-1:0]  ADR_ONE  = ADR_W'(1);
    localparam logic [DONE_W-1:0] DONE_ONE = DONE_W'(1);

    dma_state_t        state;
    dma_state_t        state_nxt;
    dma_cmd_t          cmd_in;
    dma_cmd_t          cmd_head;
    logic              fifo_empty;
    logic              fifo_aempty;
    logic              fifo_full;
    logic              fifo_pop;
    logic              cmd_load;
    logic              done_inc;
    logic              read_q;
    logic              read_nxt;
    logic              accept;
    logic              issue_ok;
    logic [ADR_W-1:0]  addr_q;
    logic [ADR_W-1:0]  remaining_q;
    logic [PEND_W-1:0] pending_q;
    logic [PEND_W-1:0] pending_nxt;
    logic [DONE_W-1:0] done_cnt_q;
    logic              ovf_q;
    logic [DATA_W-1:0] dout_q;
    logic              dout_dv_q;

    assign cmd_in = '{adr: START_ADR, size: BUF_SIZE};

    dma_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk    (CLK),
        .rst_n  (ARST_N),
        .push   (START),
        .wdata  (cmd_in),
        .pop    (fifo_pop),
        .rdata  (cmd_head),
        .empty  (fifo_empty),
        .aempty (fifo_aempty),
        .full   (fifo_full)
    );

    // Read request handshake: SDRAM_READ with SDRAM_ADDRESS is the valid side and
    // !SDRAM_WAITREQUEST is the ready side; a word is accepted on a cycle where both
    // hold, and a raised request keeps its address unchanged until that cycle.
    assign accept = read_q & ~SDRAM_WAITREQUEST;

    // Accept and return in the same cycle cancel out; a stray return never underflows.
    always_comb begin
        pending_nxt = pending_q;
        if (accept && !SDRAM_READDATAVALID) begin
            pending_nxt = pending_q + PEND_ONE;
        end else if (!accept && SDRAM_READDATAVALID && (pending_q != '0)) begin
            pending_nxt = pending_q - PEND_ONE;
        end
    end

    assign issue_ok = (pending_nxt < PEND_MAX) & ~DST_AFULL;

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        cmd_load  = 1'b0;
        done_inc  = 1'b0;
        read_nxt  = read_q;
        case (state)
            ST_IDLE: begin
                read_nxt = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    cmd_load  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (remaining_q == '0) begin
                    done_inc  = 1'b1;
                    read_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end else begin
                    read_nxt  = issue_ok;
                    state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                // Throttling only gates a fresh request; a waiting one is held as is.
                if (accept) begin
                    if (remaining_q == ADR_ONE) begin
                        read_nxt  = 1'b0;
                        state_nxt = ST_DRAIN;
                    end else begin
                        read_nxt = issue_ok;
                    end
                end else if (!read_q) begin
                    read_nxt = issue_ok;
                end
            end
            ST_DRAIN: begin
                read_nxt = 1'b0;
                if (pending_nxt == '0) begin
                    done_inc  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                read_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The head entry is captured on the pop edge, so LOAD sees it in addr_q/remaining_q.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else if (cmd_load) begin
            addr_q      <= cmd_head.adr;
            remaining_q <= cmd_head.size;
        end else if (accept) begin
            addr_q      <= addr_q + ADR_ONE;
            remaining_q <= remaining_q - ADR_ONE;
        end
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            read_q     <= 1'b0;
            pending_q  <= '0;
            done_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            read_q    <= read_nxt;
            pending_q <= pending_nxt;
            if (done_inc) begin
                done_cnt_q <= done_cnt_q + DONE_ONE;
            end
            if (START && fifo_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Return data is forwarded in every state, including after the buffer finished.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            dout_q    <= '0;
            dout_dv_q <= 1'b0;
        end else begin
            dout_dv_q <= SDRAM_READDATAVALID;
            if (SDRAM_READDATAVALID) begin
                dout_q <= SDRAM_READDATA;
            end
        end
    end

    assign DONE_CNT        = done_cnt_q;
    assign CMD_FIFO_EMPTY  = fifo_empty;
    assign CMD_FIFO_AEMPTY = fifo_aempty;
    assign CMD_OVF         = ovf_q;
    assign BUSY            = (state != ST_IDLE);
    assign DOUT            = dout_q;
    assign DOUT_DV         = dout_dv_q;
    assign SDRAM_ADDRESS   = addr_q;
    assign SDRAM_READ      = read_q;
    assign DBG_STATE       = state;

endmodule

// File: tb/tb_simple_dma_reader.sv
// Directed bench for simple_dma_reader: an SDRAM slave model with programmable
// waitrequest/return throttling, and address/data scoreboards fed from the commands.
module tb_simple_dma_reader;
    import simple_dma_reader_pkg::*;

    localparam int MAXP = 16;

    logic              CLK = 1'b0;
    logic              ARST_N;
    logic [ADR_W-1:0]  START_ADR;
    logic [ADR_W-1:0]  BUF_SIZE;
    logic              START;
    logic [DONE_W-1:0] DONE_CNT;
    logic              CMD_FIFO_EMPTY;
    logic              CMD_FIFO_AEMPTY;
    logic              CMD_OVF;
    logic              BUSY;
    logic              DST_AFULL;
    logic [DATA_W-1:0] DOUT;
    logic              DOUT_DV;
    logic [ADR_W-1:0]  SDRAM_ADDRESS;
    logic              SDRAM_READ;
    logic              SDRAM_WAITREQUEST;
    logic [DATA_W-1:0] SDRAM_READDATA;
    logic              SDRAM_READDATAVALID;
    dma_state_t        DBG_STATE;

    simple_dma_reader #(
        .CMD_DEPTH   (8),
        .MAX_PENDING (MAXP)
    ) dut (
        .CLK                 (CLK),
        .ARST_N              (ARST_N),
        .START_ADR           (START_ADR),
        .BUF_SIZE            (BUF_SIZE),
        .START               (START),
        .DONE_CNT            (DONE_CNT),
        .CMD_FIFO_EMPTY      (CMD_FIFO_EMPTY),
        .CMD_FIFO_AEMPTY     (CMD_FIFO_AEMPTY),
        .CMD_OVF             (CMD_OVF),
        .BUSY                (BUSY),
        .DST_AFULL           (DST_AFULL),
        .DOUT                (DOUT),
        .DOUT_DV             (DOUT_DV),
        .SDRAM_ADDRESS       (SDRAM_ADDRESS),
        .SDRAM_READ          (SDRAM_READ),
        .SDRAM_WAITREQUEST   (SDRAM_WAITREQUEST),
        .SDRAM_READDATA      (SDRAM_READDATA),
        .SDRAM_READDATAVALID (SDRAM_READDATAVALID),
        .DBG_STATE           (DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        int              due;
        logic [ADR_W-1:0] adr;
    } resp_t;

    logic [DATA_W-1:0] exp_q[$];
    logic [ADR_W-1:0]  exp_adr_q[$];
    resp_t             resp_q[$];
    logic [DONE_W-1:0] exp_done;
    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int acc_cnt = 0;
    int dv_cnt  = 0;
    int rdv_budget = -1;
    int wait_idx   = -1;
    int wait_left  = 0;
    bit wait_started = 1'b0;
    int first_acc = -1;
    int last_acc  = -1;
    bit read_seen = 1'b0;

    function automatic logic [DATA_W-1:0] data_of(input logic [ADR_W-1:0] a);
        return {4'h1, a, 4'h2, ~a, 4'h3, a ^ 28'h5A5A5A5, 4'h4, a + 28'd7};
    endfunction

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- SDRAM slave model + output monitor ----------------
    always @(negedge CLK) begin
        resp_t r;
        cyc++;
        if (!ARST_N) begin
            resp_q.delete();
            SDRAM_WAITREQUEST   = 1'b0;
            SDRAM_READDATAVALID = 1'b0;
            wait_left    = 0;
            wait_started = 1'b0;
        end else begin
            if (DOUT_DV) begin
                dv_cnt++;
                if (exp_q.size() == 0) check("dout_unexpected", 1, 0);
                else check("dout_data", DOUT, exp_q.pop_front());
            end
            if (SDRAM_READ) read_seen = 1'b1;

            SDRAM_WAITREQUEST = 1'b0;
            if (wait_left > 0 && (wait_started || (SDRAM_READ && acc_cnt == wait_idx))) begin
                wait_started = 1'b1;
                wait_left--;
                SDRAM_WAITREQUEST = 1'b1;
                check("wait_read_held", SDRAM_READ, 1);
                check("wait_addr_held", SDRAM_ADDRESS,
                      (exp_adr_q.size() != 0) ? exp_adr_q[0] : 28'bx);
            end

            SDRAM_READDATAVALID = 1'b0;
            if (resp_q.size() != 0 && resp_q[0].due <= cyc && rdv_budget != 0) begin
                r = resp_q.pop_front();
                SDRAM_READDATAVALID = 1'b1;
                SDRAM_READDATA      = data_of(r.adr);
                if (rdv_budget > 0) rdv_budget--;
            end

            // The request seen now is accepted at the next rising edge.
            if (SDRAM_READ && !SDRAM_WAITREQUEST) begin
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                if (exp_adr_q.size() == 0) check("addr_unexpected", 1, 0);
                else check("rd_addr", SDRAM_ADDRESS, exp_adr_q.pop_front());
                resp_q.push_back('{due: cyc + 3, adr: SDRAM_ADDRESS});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic queue_cmd(input logic [ADR_W-1:0] adr, input logic [ADR_W-1:0] size);
        logic [ADR_W-1:0] a;
        for (int i = 0; i < int'(size); i++) begin
            a = adr + ADR_W'(i);
            exp_adr_q.push_back(a);
            exp_q.push_back(data_of(a));
        end
        exp_done++;
    endtask

    task automatic push_cmd(input logic [ADR_W-1:0] adr, input logic [ADR_W-1:0] size);
        START_ADR = adr;
        BUF_SIZE  = size;
        START     = 1'b1;
        queue_cmd(adr, size);
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input logic [DONE_W-1:0] target);
        int n = 0;
        while (DONE_CNT !== target && n < 3000) begin
            tick();
            n++;
        end
        check("done_cnt", DONE_CNT, target);
    endtask

    task automatic drain(input string tag);
        tick(3);
        check({tag, "_busy_idle"}, BUSY, 0);
        check({tag, "_data_drained"}, exp_q.size(), 0);
        check({tag, "_addr_drained"}, exp_adr_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int snap;
        int snap2;
        int n;
        ARST_N            = 1'b0;
        START             = 1'b0;
        START_ADR         = '0;
        BUF_SIZE          = '0;
        DST_AFULL         = 1'b0;
        SDRAM_WAITREQUEST = 1'b0;
        SDRAM_READDATA    = '0;
        SDRAM_READDATAVALID = 1'b0;
        exp_done          = '0;
        tick(3);

        check("rst_done_cnt", DONE_CNT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_empty", CMD_FIFO_EMPTY, 1);
        check("rst_aempty", CMD_FIFO_AEMPTY, 1);
        check("rst_ovf", CMD_OVF, 0);
        check("rst_read", SDRAM_READ, 0);
        check("rst_address", SDRAM_ADDRESS, 0);
        check("rst_dout_dv", DOUT_DV, 0);
        check("rst_dout", DOUT, 0);
        check("rst_state", DBG_STATE, ST_IDLE);
        ARST_N = 1'b1;
        tick(2);

        // Basic 4-word buffer: back-to-back accepts, 3-cycle return latency.
        first_acc = -1;
        push_cmd(28'h100, 28'd4);
        wait_done(exp_done);
        drain("t1");
        check("t1_consecutive", last_acc - first_acc, 3);

        // Waitrequest held for 5 cycles on the second read.
        first_acc = -1;
        snap = acc_cnt;
        wait_started = 1'b0;
        wait_idx  = acc_cnt + 1;
        wait_left = 5;
        push_cmd(28'h100, 28'd4);
        wait_done(exp_done);
        drain("t2");
        check("t2_accepts", acc_cnt - snap, 4);
        check("t2_span", last_acc - first_acc, 8);

        // Pending limit with returns withheld, then released one at a time.
        rdv_budget = 0;
        snap = acc_cnt;
        push_cmd(28'h8000, 28'd64);
        tick(40);
        check("t3_limit_accepts", acc_cnt - snap, MAXP);
        check("t3_limit_read_low", SDRAM_READ, 0);
        rdv_budget = 1;
        tick(10);
        check("t3_one_return_one_accept", acc_cnt - snap, MAXP + 1);
        check("t3_read_low_again", SDRAM_READ, 0);
        rdv_budget = -1;
        wait_done(exp_done);
        drain("t3");

        // Downstream almost-full mid-buffer.
        snap = acc_cnt;
        push_cmd(28'h4000, 28'd32);
        n = 0;
        while (acc_cnt - snap < 5 && n < 100) begin
            tick();
            n++;
        end
        DST_AFULL = 1'b1;
        snap2 = acc_cnt;
        n = dv_cnt;
        tick(12);
        check("t4_no_issue_afull", acc_cnt - snap2, 0);
        check("t4_read_low_afull", SDRAM_READ, 0);
        check("t4_inflight_forwarded", dv_cnt > n, 1);
        DST_AFULL = 1'b0;
        wait_done(exp_done);
        drain("t4");

        // Command FIFO overflow while a long buffer is in progress.
        push_cmd(28'h2000, 28'd40);
        n = 0;
        while (!BUSY && n < 20) begin
            tick();
            n++;
        end
        check("t5_busy", BUSY, 1);
        for (int i = 0; i < 9; i++) begin
            START     = 1'b1;
            START_ADR = 28'h3000 + ADR_W'(16 * i);
            BUF_SIZE  = 28'd2;
            if (i < 8) queue_cmd(START_ADR, BUF_SIZE);
            tick();
        end
        START = 1'b0;
        check("t5_ovf", CMD_OVF, 1);
        check("t5_not_empty", CMD_FIFO_EMPTY, 0);
        check("t5_not_aempty", CMD_FIFO_AEMPTY, 0);
        wait_done(exp_done);
        drain("t5");
        check("t5_ovf_sticky", CMD_OVF, 1);
        check("t5_empty_after", CMD_FIFO_EMPTY, 1);

        // Zero-length buffer completes without touching the bus.
        snap = acc_cnt;
        read_seen = 1'b0;
        push_cmd(28'h5000, 28'd0);
        wait_done(exp_done);
        check("t5z_no_read", read_seen, 0);
        check("t5z_no_accept", acc_cnt - snap, 0);
        drain("t5z");

        // Address wrap at the top of the 28-bit space.
        push_cmd(28'hFFFFFFE, 28'd4);
        wait_done(exp_done);
        drain("t6");
        check("t6_addr_wrapped", SDRAM_ADDRESS, 28'h2);

        // Asynchronous reset in the middle of a read burst.
        snap = acc_cnt;
        push_cmd(28'h6000, 28'd20);
        n = 0;
        while (acc_cnt - snap < 3 && n < 100) begin
            tick();
            n++;
        end
        #2;
        ARST_N = 1'b0;
        #1;
        check("t7_read_dropped", SDRAM_READ, 0);
        check("t7_busy", BUSY, 0);
        check("t7_empty", CMD_FIFO_EMPTY, 1);
        check("t7_done_cnt", DONE_CNT, 0);
        check("t7_ovf_cleared", CMD_OVF, 0);
        exp_q.delete();
        exp_adr_q.delete();
        exp_done = '0;
        tick(2);
        ARST_N = 1'b1;
        tick(2);
        push_cmd(28'h7000, 28'd2);
        wait_done(exp_done);
        drain("t7");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/simple_dma_reader.md
Name: simple_dma_reader

Overview:
- Avalon-MM read master: fetches 128-bit words from SDRAM into a downstream stream/FIFO.
- Counterpart of the FIFO-to-SDRAM write DMA; used for playback/readout of captured line buffers.
- Commands (start address, length) are queued in a small internal command FIFO; one buffer is processed at a time.
- Completions are reported through a free-running done counter.

Parameters:
- CMD_DEPTH, 8: command FIFO depth in entries; power of 2.
- MAX_PENDING, 16: maximum outstanding read transactions; 1..255.

Ports:
- CLK  in  1  single clock; SDRAM side and stream side
- ARST_N  in  1  reset; asynchronous, active-low
- START_ADR  in  28  buffer start word address, sampled on START
- BUF_SIZE  in  28  buffer length in 128-bit words, sampled on START
- START  in  1  one-cycle pulse; pushes {START_ADR, BUF_SIZE} into the command FIFO
- DONE_CNT  out  16  count of fully returned buffers; wraps at 2^16
- CMD_FIFO_EMPTY  out  1  command FIFO empty
- CMD_FIFO_AEMPTY  out  1  command FIFO occupancy <= 1
- CMD_OVF  out  1  sticky flag: START arrived while the command FIFO was full
- BUSY  out  1  state != IDLE
- DST_AFULL  in  1  downstream almost-full; blocks issue of new reads
- DOUT  out  128  read data to downstream
- DOUT_DV  out  1  DOUT valid; no backpressure
- SDRAM_ADDRESS  out  28  read word address
- SDRAM_READ  out  1  read request
- SDRAM_WAITREQUEST  in  1  Avalon waitrequest
- SDRAM_READDATA  in  128  read data
- SDRAM_READDATAVALID  in  1  read data valid

Behaviour:
- Reset (ARST_N low, asynchronous):
  - all outputs 0, except CMD_FIFO_EMPTY = 1 and CMD_FIFO_AEMPTY = 1;
  - FSM goes to IDLE; command FIFO is flushed; pending count = 0.
  - Reset mid-transfer abandons the transfer. SDRAM_READ drops immediately. The controller must be reset with the block.
- Command push: START with FIFO not full -> entry written next edge. START with FIFO full -> command dropped, CMD_OVF set (cleared only by reset).
- FSM states: IDLE, LOAD, RD, DRAIN.
  - IDLE: command FIFO non-empty -> pop -> LOAD.
  - LOAD: latch addr = START_ADR, remaining = BUF_SIZE.
    - remaining == 0 -> DONE_CNT += 1 next cycle -> IDLE, with no bus activity.
    - otherwise -> RD.
  - RD: SDRAM_READ = 1 while pending < MAX_PENDING and !DST_AFULL.
    - SDRAM_ADDRESS and SDRAM_READ are registered and held stable while SDRAM_WAITREQUEST = 1.
    - DST_AFULL or the pending limit may only withhold a new request. An already asserted request must stay asserted until accepted.
    - Accept = SDRAM_READ & !SDRAM_WAITREQUEST. On accept: addr += 1 (mod 2^28, wraps silently), remaining -= 1, pending += 1.
    - Accepting the last word -> DRAIN; SDRAM_READ drops the following cycle.
  - DRAIN: pending == 0 (including a same-cycle final readdatavalid) -> DONE_CNT += 1 -> IDLE.
- Pending counter:
  - width $clog2(MAX_PENDING+1);
  - accept and readdatavalid in the same cycle -> unchanged;
  - decrement saturates at 0 (spurious readdatavalid is tolerated).
- Data path: DOUT / DOUT_DV = SDRAM_READDATA / SDRAM_READDATAVALID registered once (1-cycle latency), order preserved. Data is forwarded in all states.
- Maximum throughput: 1 word per cycle with zero waitrequest and pending < MAX_PENDING.
- DONE_CNT increments by exactly 1 per command and wraps 0xFFFF -> 0.

Decomposition:
- Shared package: address/size width (28), data width (128), done counter width (16), FSM state enum.
- Sub-module: dma_cmd_fifo, a synchronous FIFO of width 56 and depth CMD_DEPTH with empty/aempty/full flags, async active-low reset.

Test Plan:
- START_ADR=0x100, BUF_SIZE=4, no waitrequest, readdatavalid 3 cycles after accept -> reads issued to 0x100..0x103 in 4 consecutive cycles; 4 DOUT_DV pulses with matching data in order; DONE_CNT 0 -> 1; BUSY back to 0.
- Same command, SDRAM_WAITREQUEST held high 5 cycles on the second read -> address 0x101 held stable with SDRAM_READ = 1 throughout; no duplicate or missing reads.
- BUF_SIZE=64, MAX_PENDING=16, readdatavalid withheld -> exactly 16 accepts then SDRAM_READ = 0; each returned word enables one new accept; DONE_CNT += 1 after the 64th word.
- DST_AFULL asserted mid-buffer -> no new requests issued while it is high; in-flight data is still forwarded; issue resumes after deassertion.
- 9 START pulses back-to-back with CMD_DEPTH=8 while busy -> CMD_OVF = 1; remaining commands complete (DONE_CNT reaches 8, or 9 if one was already popped); BUF_SIZE=0 command -> DONE_CNT += 1 with no SDRAM_READ.
- START_ADR=0xFFFFFFE, BUF_SIZE=4 -> addresses 0xFFFFFFE, 0xFFFFFFF, 0x0, 0x1.
- ARST_N pulsed low mid-RD -> SDRAM_READ = 0 immediately, BUSY = 0, CMD_FIFO_EMPTY = 1, DONE_CNT = 0.
